// File: rtl/tile_addr_gen_if.sv
// Beat stream between the tile address generator and the tile ROM / pixel write stage.
// Control inputs plus the registered address, raster position and frame markers.
interface tile_addr_gen_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 10
) ();
  logic              enable;
  logic              restart;
  logic [1:0]        mode;
  logic              out_ready;
  logic              addr_valid;
  logic [ADDR_W-1:0] rom_address;
  logic [XW-1:0]     pixel_x;
  logic [YW-1:0]     pixel_y;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    input  enable, restart, mode, out_ready,
    output addr_valid, rom_address, pixel_x, pixel_y, sof, eol, eof
  );

  modport slave (
    output enable, restart, mode, out_ready,
    input  addr_valid, rom_address, pixel_x, pixel_y, sof, eol, eof
  );
endinterface

// File: rtl/tile_addr_gen.sv
// Back-pressured raster scanner emitting the texel ROM address of a repeated, optionally
// mirrored tile for every pixel. Tile coordinates and row base are tracked incrementally.
module tile_addr_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned TILE_W   = 80,
  parameter int unsigned TILE_H   = 60,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input logic             clk,
  input logic             rst_n,
  tile_addr_gen_if.master bus
);

  localparam logic [XW-1:0]     XLast       = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     YLast       = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0]     TxLast      = XW'(TILE_W - 1);
  localparam logic [YW-1:0]     TyLast      = YW'(TILE_H - 1);
  localparam logic [ADDR_W-1:0] TileW       = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] TxMax       = ADDR_W'(TILE_W - 1);
  localparam logic [ADDR_W-1:0] LastRowBase = ADDR_W'((TILE_H - 1) * TILE_W);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e st_q, st_d;

  // Registered beat
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic              sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;

  // Position of the next beat to be loaded
  logic [XW-1:0]     x_q, x_d, tx_q, tx_d;
  logic [YW-1:0]     y_q, y_d, ty_q, ty_d;
  logic              col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        mode_q, mode_d;

  logic              adv, sel_origin, is_origin;
  logic [XW-1:0]     cx, ctx;
  logic [YW-1:0]     cy, cty;
  logic              ccol, crow;
  logic [ADDR_W-1:0] cbase, tx_m;
  logic [1:0]        mode_eff;

  always_comb begin
    st_d    = st_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    px_d    = px_q;
    py_d    = py_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    mode_d  = mode_q;

    // IDLE or a restart forces the loaded position back to the frame origin.
    sel_origin = (st_q == StIdle) || bus.restart;
    cx    = sel_origin ? '0 : x_q;
    cy    = sel_origin ? '0 : y_q;
    ctx   = sel_origin ? '0 : tx_q;
    cty   = sel_origin ? '0 : ty_q;
    ccol  = sel_origin ? 1'b0 : col_q;
    crow  = sel_origin ? 1'b0 : row_q;
    cbase = sel_origin ? '0 : base_q;

    is_origin = (cx == '0) && (cy == '0);
    mode_eff  = is_origin ? bus.mode : mode_q;
    adv       = bus.enable && (!valid_q || bus.out_ready);
    tx_m      = (mode_eff[0] && ccol) ? (TxMax - ADDR_W'(ctx)) : ADDR_W'(ctx);

    if (adv) begin
      st_d    = StRun;
      valid_d = 1'b1;
      addr_d  = cbase + tx_m;
      px_d    = cx;
      py_d    = cy;
      sof_d   = is_origin;
      eol_d   = (cx == XLast);
      eof_d   = (cx == XLast) && (cy == YLast);
      mode_d  = mode_eff;

      if (cx != XLast) begin
        x_d    = cx + XW'(1);
        y_d    = cy;
        ty_d   = cty;
        row_d  = crow;
        base_d = cbase;
        if (ctx == TxLast) begin
          tx_d  = '0;
          col_d = ~ccol;
        end else begin
          tx_d  = ctx + XW'(1);
          col_d = ccol;
        end
      end else begin
        x_d   = '0;
        tx_d  = '0;
        col_d = 1'b0;
        if (cy == YLast) begin
          y_d    = '0;
          ty_d   = '0;
          row_d  = 1'b0;
          base_d = '0;
        end else begin
          y_d = cy + YW'(1);
          if (cty == TyLast) begin
            // Entering a new tile row: mirrored odd rows start from the last texel row.
            ty_d   = '0;
            row_d  = ~crow;
            base_d = (mode_eff[1] && !crow) ? LastRowBase : '0;
          end else begin
            ty_d   = cty + YW'(1);
            row_d  = crow;
            base_d = (mode_eff[1] && crow) ? (cbase - TileW) : (cbase + TileW);
          end
        end
      end
    end else if (bus.restart) begin
      valid_d = 1'b0;
      st_d    = StIdle;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      col_q   <= 1'b0;
      row_q   <= 1'b0;
      base_q  <= '0;
      mode_q  <= '0;
    end else begin
      st_q    <= st_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.addr_valid  = valid_q;
  assign bus.rom_address = addr_q;
  assign bus.pixel_x     = px_q;
  assign bus.pixel_y     = py_q;
  assign bus.sof         = sof_q;
  assign bus.eol         = eol_q;
  assign bus.eof         = eof_q;

endmodule

// File: doc/tile_addr_gen.md
# tile_addr_gen

Parametrised, back-pressured tile-address generator for the display path. Scans an H_ACTIVE x V_ACTIVE raster and, per pixel, emits the ROM address of the corresponding texel of a TILE_W x TILE_H tile repeated across the screen, with optional per-tile X/Y mirroring. Sits between the frame-timing logic and the tile ROM / pixel write stage, replacing the fixed 640x480 / 80x60 generator with a valid/ready stream.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- TILE_W, 80, tile width in texels
- TILE_H, 60, tile height in texels; TILE_W*TILE_H <= 2^ADDR_W
- ADDR_W, 13, ROM address width
- XW, 10, pixel_x width; H_ACTIVE <= 2^XW
- YW, 10, pixel_y width; V_ACTIVE <= 2^YW
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  allow the generator to produce new beats
- restart  in  1  synchronous abort; next beat is (0,0) of a new frame
- mode  in  2  bit0 mirror-X on odd tile columns, bit1 mirror-Y on odd tile rows
- out_ready  in  1  downstream accepts current beat
- addr_valid  out  1  rom_address and sideband are valid
- rom_address  out  ADDR_W  texel address = ty*TILE_W + tx (after mirroring)
- pixel_x  out  XW  raster column of current beat
- pixel_y  out  YW  raster line of current beat
- sof  out  1  current beat is (0,0)
- eol  out  1  current beat is x = H_ACTIVE-1
- eof  out  1  current beat is (H_ACTIVE-1, V_ACTIVE-1)

## Operation
- States: IDLE (no beat held, next position = (0,0)), RUN (beat held or in progress).
- Advance condition: adv = enable && (!addr_valid || out_ready). On adv, all outputs load the next position and addr_valid=1.
- If addr_valid && !out_ready: every output holds, regardless of enable/mode.
- If !enable && addr_valid && out_ready: addr_valid drops next cycle; position counters keep the next position (resume continues raster, no skip or repeat).
- Raster: x counts 0..H_ACTIVE-1; at wrap x=0, y+1; at (H_ACTIVE-1, V_ACTIVE-1) wrap to (0,0). No 641st column / 481st line.
- Tile coordinates kept incrementally (no multiplier/divider): tx wraps 0..TILE_W-1 with x, resets at x=0; ty wraps 0..TILE_H-1 per line, resets at y=0; col parity toggles on each tx wrap, row parity on each ty wrap. Partial last tiles (H_ACTIVE not a multiple of TILE_W) are truncated, not stretched.
- Mirroring: tx' = (mode[0] && odd col) ? TILE_W-1-tx : tx; ty' likewise with mode[1]. rom_address = ty'*TILE_W + tx', maintained as a row base stepped by +TILE_W / -TILE_W / reloaded at tile-row boundaries; all sums modulo 2^ADDR_W, never exceeding TILE_W*TILE_H-1.
- mode is sampled only when the (0,0) beat is loaded; mid-frame changes take effect next frame.
- restart: next loaded beat is (0,0) with sof=1, mode resampled; a held unaccepted beat is dropped (addr_valid=0 next cycle unless adv loads (0,0) in the same cycle). restart outranks backpressure.

## Timing
- Reset (rst_n low, async): addr_valid=0, rom_address=0, pixel_x=0, pixel_y=0, sof=eol=eof=0, state IDLE, next position (0,0), latched mode=0.
- Release: first beat (0,0) valid one cycle after first clk edge with enable=1.
- Throughput 1 beat/cycle with out_ready held high; sustained frame = H_ACTIVE*V_ACTIVE cycles.
- All outputs registered; no combinational path from out_ready/enable to outputs.
- Reset asserted mid-frame: outputs clear immediately; next frame starts at (0,0).
- sof/eol/eof are qualified by addr_valid and stable while stalled.

## Test plan
- Defaults, mode=0, out_ready=1: beats (0,0)->0, (79,0)->79, (80,0)->0, (0,1)->80, (79,59)->4799, (0,60)->0, (639,479)->4799 with eol=eof=1, next beat (0,0) with sof=1.
- mode=1: (80,0)->79, (81,0)->78, (160,0)->0; mode=2: (0,60)->4720, (0,119)->0; mode=3: (80,60)->4799.
- Backpressure: out_ready low 3 cycles at (100,5) -> outputs hold (100,5), address 5*80+20=420, for all 3 cycles; then (101,5)->421.
- enable low 4 cycles at (10,0): addr_valid drops after acceptance; on re-enable next beat is (11,0)->11, no gap or repeat.
- restart at (300,200) while stalled -> next valid beat (0,0), sof=1, address 0; mode change at (5,5) ignored until next sof.
- Params H_ACTIVE=10, V_ACTIVE=4, TILE_W=4, TILE_H=3: (8,0)->0, (9,0)->1, (0,3)->0; async rst_n pulse mid-line clears addr_valid without clk edge.
